// File: rtl/tppe_pkg.sv
// Shared types and defaults for the Fibre A store and its read pipeline.
// Build option: FIBRE_A_BYPASS_EN (used by fibre_a_store / fibre_a_rd_pipe).
package tppe_pkg;

    localparam int DEF_TIMESTEPS  = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef logic [DEF_TIMESTEPS-1:0]  fibre_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] fa_addr_t;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } fa_state_t;

endpackage

// File: rtl/fibre_a_rd_pipe.sv
// Fixed-latency read response pipeline for the Fibre A store.
// With FIBRE_A_BYPASS_EN defined, each stage also carries its address so that
// writes accepted while a read is in flight are forwarded into that read.
module fibre_a_rd_pipe #(
    parameter int TIMESTEPS    = 8,
`ifdef FIBRE_A_BYPASS_EN
    parameter int ADDR_WIDTH   = 8,
`endif
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [TIMESTEPS-1:0]  in_data,
`ifdef FIBRE_A_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  wr_fire,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [TIMESTEPS-1:0]  wr_data,
`endif
    output logic                  out_valid,
    output logic [TIMESTEPS-1:0]  out_data
);

    logic                 vld     [READ_LATENCY];
    logic [TIMESTEPS-1:0] dat     [READ_LATENCY];
    logic                 nxt_vld [READ_LATENCY];
    logic [TIMESTEPS-1:0] nxt_dat [READ_LATENCY];
`ifdef FIBRE_A_BYPASS_EN
    logic [ADDR_WIDTH-1:0] adr     [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] nxt_adr [READ_LATENCY];
`endif

    // Build the value each stage will load next: stage 0 takes the new request, later stages take their predecessor.
    always_comb begin
        nxt_vld[0] = in_valid;
        nxt_dat[0] = in_data;
`ifdef FIBRE_A_BYPASS_EN
        nxt_adr[0] = in_addr;
`endif
        for (int i = 1; i < READ_LATENCY; i++) begin
            nxt_vld[i] = vld[i-1];
            nxt_dat[i] = dat[i-1];
`ifdef FIBRE_A_BYPASS_EN
            nxt_adr[i] = adr[i-1];
`endif
        end
`ifdef FIBRE_A_BYPASS_EN
        for (int i = 0; i < READ_LATENCY; i++) begin
            if (wr_fire && nxt_vld[i] && (nxt_adr[i] == wr_addr)) begin
                nxt_dat[i] = wr_data;
            end
        end
`endif
    end

    // Shift the pipeline every cycle; data only moves with a valid so the output holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld[i] <= 1'b0;
                dat[i] <= '0;
`ifdef FIBRE_A_BYPASS_EN
                adr[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld[i] <= nxt_vld[i];
                if (nxt_vld[i]) begin
                    dat[i] <= nxt_dat[i];
`ifdef FIBRE_A_BYPASS_EN
                    adr[i] <= nxt_adr[i];
`endif
                end
            end
        end
    end

    assign out_valid = vld[READ_LATENCY-1];
    assign out_data  = dat[READ_LATENCY-1];

endmodule

// File: rtl/fibre_a_store.sv
// Fibre A responder store: spike-vector array, zero-fill sweep FSM, write port,
// fixed-latency read responses, sticky address error and a read counter.
// Build option: FIBRE_A_BYPASS_EN forwards same-address write data into reads.
module fibre_a_store
    import tppe_pkg::*;
#(
    parameter int TIMESTEPS    = DEF_TIMESTEPS,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DEPTH        = 128,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
    input  logic                  fibre_a_read_en,
    output logic [TIMESTEPS-1:0]  fibre_a_data,
    output logic                  fibre_a_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [TIMESTEPS-1:0]  wr_data,
    output logic                  wr_ready,
    output logic                  addr_err,
    output logic [15:0]           read_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TIMESTEPS-1:0] mem [DEPTH];
    fa_state_t            state;
    fa_state_t            state_next;
    logic [IDX_W-1:0]     sweep_ptr;
    logic                 sweep_last;
    logic                 rd_in_range;
    logic                 wr_in_range;
    logic                 rd_masked;
    logic                 wr_fire;
    logic [TIMESTEPS-1:0] rd_raw;

    assign sweep_last  = (sweep_ptr == IDX_W'(DEPTH - 1));
    assign rd_in_range = (32'(fibre_a_addr) < DEPTH);
    assign wr_in_range = (32'(wr_addr) < DEPTH);
    assign rd_masked   = (state == ST_INIT) && (32'(fibre_a_addr) >= 32'(sweep_ptr));
    assign wr_fire     = (state == ST_READY) && wr_en && wr_in_range;
    assign wr_ready    = (state == ST_READY);

    // Read-before-write array lookup; out-of-range and not-yet-swept entries read as zero.
    always_comb begin
        rd_raw = '0;
        if (rd_in_range && !rd_masked) begin
            rd_raw = mem[fibre_a_addr[IDX_W-1:0]];
        end
    end

    // Array write port: the sweep owns it during INIT, the loader afterwards.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[sweep_ptr] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // State register and sweep pointer; reset restarts the zero-fill from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_INIT) && !sweep_last) begin
                sweep_ptr <= sweep_ptr + 1'b1;
            end
        end
    end

    // Leave INIT once the last entry has been cleared; READY is held until reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:  if (sweep_last) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_INIT;
        endcase
    end

    // Sticky error for any accepted-slot access outside the array; writes dropped in INIT do not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if ((fibre_a_read_en && !rd_in_range) ||
                     ((state == ST_READY) && wr_en && !wr_in_range)) begin
            addr_err <= 1'b1;
        end
    end

    // Saturating count of every sampled read request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_count <= '0;
        end else if (fibre_a_read_en && (read_count != 16'hFFFF)) begin
            read_count <= read_count + 16'd1;
        end
    end

    fibre_a_rd_pipe #(
        .TIMESTEPS    (TIMESTEPS),
`ifdef FIBRE_A_BYPASS_EN
        .ADDR_WIDTH   (ADDR_WIDTH),
`endif
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fibre_a_read_en),
        .in_data   (rd_raw),
`ifdef FIBRE_A_BYPASS_EN
        .in_addr   (fibre_a_addr),
        .wr_fire   (wr_fire),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`endif
        .out_valid (fibre_a_valid),
        .out_data  (fibre_a_data)
    );

endmodule
